// File: rtl/ir_pkg.sv
// Frame layout shared by the IR receiver, command scheduler and LED manager.
// Address occupies the upper bits and the command the lower bits of each 12-bit frame.
package ir_pkg;

    localparam int IR_DATA_W   = 12;
    localparam int IR_CMD_LSB  = 0;
    localparam int IR_CMD_W    = 7;
    localparam int IR_ADDR_LSB = 7;
    localparam int IR_ADDR_W   = 5;

    typedef logic [IR_DATA_W-1:0] ir_frame_t;

    function automatic logic [IR_ADDR_W-1:0] ir_addr(input ir_frame_t f);
        return f[IR_ADDR_LSB +: IR_ADDR_W];
    endfunction

    function automatic logic [IR_CMD_W-1:0] ir_cmd(input ir_frame_t f);
        return f[IR_CMD_LSB +: IR_CMD_W];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with an occupancy counter and a registered head word.
// Latency: a push into an empty FIFO shows at head_dat the next cycle.
// Backpressure: a push while full is accepted only with a same-cycle pop; pop while empty is ignored.
module cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_en, pop_en;

    assign full     = (count_q == LVL_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign head_dat = head_q;

    always_comb begin
        pop_en  = pop & ~empty;
        push_en = push & (~full | pop_en);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_en) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        // The slot being written this cycle may be the next head (empty, or one entry being replaced).
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_en && (wr_q == rd_d)) begin
            head_d = push_dat;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Classifies IR frames (address filter, key-hold repeat suppression) and queues accepted commands.
// Latency: frame edge in cycle N gives cmd_valid in N+1 when the queue was empty.
// Backpressure: cmd_valid/cmd_ready; frames arriving while the queue is full are counted and dropped.
module ir_cmd_scheduler
    import ir_pkg::*;
#(
    parameter int                   DATA_W         = 12,
    parameter logic [IR_ADDR_W-1:0] ADDR_MATCH     = 5'h01,
    parameter bit                   ADDR_FILTER_EN = 1'b1,
    parameter int                   REPEAT_WINDOW  = 3_000_000,
    parameter int                   FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_rdy,
    output logic [DATA_W-1:0]             cmd_out,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          repeat_pulse,
    output logic                          key_held,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TIMER_W = $clog2(REPEAT_WINDOW + 1);

    typedef enum logic {ST_IDLE, ST_HOLD} rpt_state_t;

    rpt_state_t        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              last_vld_q, last_vld_d;
    logic              rpt_q, rpt_d;
    logic [7:0]        drop_q, drop_d;
    logic              rx_rdy_q;
    logic              new_frame, addr_miss, push_req, pop, fifo_full, fifo_empty;

    assign new_frame    = rx_rdy & ~rx_rdy_q;
    assign addr_miss    = ADDR_FILTER_EN && (rx_data[IR_ADDR_LSB +: IR_ADDR_W] != ADDR_MATCH);
    assign cmd_valid    = ~fifo_empty;
    assign pop          = cmd_valid & cmd_ready;
    assign key_held     = (state_q == ST_HOLD);
    assign repeat_pulse = rpt_q;
    assign drop_count   = drop_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        rpt_d      = 1'b0;
        drop_d     = drop_q;
        push_req   = 1'b0;
        if (state_q == ST_HOLD) begin
            if (timer_q <= TIMER_W'(1)) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end
        if (new_frame) begin
            if (addr_miss) begin
                drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
            end else if (last_vld_q && (state_q == ST_HOLD) && (rx_data == last_q)) begin
                rpt_d   = 1'b1;
                state_d = ST_HOLD;
                timer_d = TIMER_W'(REPEAT_WINDOW);
            end else begin
                push_req   = 1'b1;
                last_d     = rx_data;
                last_vld_d = 1'b1;
                state_d    = ST_HOLD;
                timer_d    = TIMER_W'(REPEAT_WINDOW);
                // Overflow still arms the hold window so the remote's repeats stay suppressed.
                if (fifo_full && !pop) begin
                    drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        rx_rdy_q <= rx_rdy;
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            rpt_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            rpt_q      <= rpt_d;
            drop_q     <= drop_d;
        end
    end

    cmd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .push_dat (rx_data),
        .pop      (pop),
        .head_dat (cmd_out),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler: repeat suppression, address filter, overflow, ordering, reset.
module tb_ir_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rx_data;
    logic        rx_rdy;
    logic [11:0] cmd_out;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        repeat_pulse;
    logic        key_held;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_level;

    int tests_run    = 0;
    int tests_failed = 0;
    int max_level;

    ir_cmd_scheduler #(
        .DATA_W         (12),
        .ADDR_MATCH     (5'h01),
        .ADDR_FILTER_EN (1'b1),
        .REPEAT_WINDOW  (100),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .cmd_out      (cmd_out),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .repeat_pulse (repeat_pulse),
        .key_held     (key_held),
        .drop_count   (drop_count),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises rx_rdy for one cycle; returns in the cycle after the edge.
    task automatic send(input logic [11:0] d);
        rx_data = d;
        rx_rdy  = 1'b1;
        step();
        rx_rdy  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rx_data   = '0;
        rx_rdy    = 1'b0;
        cmd_ready = 1'b0;
        step(3);
        rst = 1'b0;
        step();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_held", key_held, 0);
        chk("rst_rpt", repeat_pulse, 0);
        chk("rst_out", cmd_out, 0);

        // First frame, consumer ready: visible for exactly one cycle.
        step(5);
        cmd_ready = 1'b1;
        send(12'h095);
        chk("f1_valid", cmd_valid, 1);
        chk("f1_out", cmd_out, 12'h095);
        chk("f1_held", key_held, 1);
        chk("f1_level", fifo_level, 1);
        step();
        chk("f1_popped", cmd_valid, 0);
        chk("f1_lvl0", fifo_level, 0);

        // Repeats at +40 and +80 cycles after the first edge.
        step(38);
        send(12'h095);
        chk("rpt1_pulse", repeat_pulse, 1);
        chk("rpt1_nopush", cmd_valid, 0);
        step();
        chk("rpt1_pulse_end", repeat_pulse, 0);
        step(38);
        send(12'h095);
        chk("rpt2_pulse", repeat_pulse, 1);
        chk("rpt2_level", fifo_level, 0);
        step(89);
        chk("hold_L90", key_held, 1);
        step(20);
        chk("hold_L110", key_held, 0);

        // Same frame well after the window: accepted again.
        step(110);
        send(12'h095);
        chk("f1b_valid", cmd_valid, 1);
        chk("f1b_out", cmd_out, 12'h095);
        chk("f1b_rpt", repeat_pulse, 0);
        step();

        // Address 2 frame is filtered.
        send(12'h115);
        chk("filt_drop", drop_count, 1);
        chk("filt_held", key_held, 1);
        chk("filt_nopush", cmd_valid, 0);
        step();

        // Overflow: five frames into a four-entry queue.
        cmd_ready = 1'b0;
        max_level = 0;
        for (int i = 0; i < 5; i++) begin
            send(12'h081 + 12'(i));
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            step();
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        chk("ovf_level", fifo_level, 4);
        chk("ovf_max", max_level, 4);
        chk("ovf_drop", drop_count, 2);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), cmd_valid, 1);
            chk($sformatf("drain%0d_out", i), cmd_out, 12'h081 + 12'(i));
            step();
        end
        chk("drain_empty", cmd_valid, 0);
        cmd_ready = 1'b0;

        // Full queue with a simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            send(12'h0A1 + 12'(i));
            step();
        end
        chk("full_level", fifo_level, 4);
        cmd_ready = 1'b1;
        send(12'h0A5);
        chk("pp_level", fifo_level, 4);
        chk("pp_drop", drop_count, 2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp%0d_out", i), cmd_out, 12'h0A2 + 12'(i));
            step();
        end
        chk("pp_empty", cmd_valid, 0);
        cmd_ready = 1'b0;

        // Reset with queued entries and rx_rdy held high.
        for (int i = 0; i < 3; i++) begin
            send(12'h0B1 + 12'(i));
            step();
        end
        chk("pre_rst_level", fifo_level, 3);
        rx_data = 12'h0B4;
        rx_rdy  = 1'b1;
        rst     = 1'b1;
        step(2);
        rst = 1'b0;
        step();
        chk("post_rst_valid", cmd_valid, 0);
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_drop", drop_count, 0);
        chk("post_rst_held", key_held, 0);
        step(4);
        chk("no_spurious", fifo_level, 0);
        rx_rdy = 1'b0;
        step();
        send(12'h0B4);
        chk("re_edge_valid", cmd_valid, 1);
        chk("re_edge_out", cmd_out, 12'h0B4);
        chk("re_edge_level", fifo_level, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
